pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined successor to the team's 32-bit single-cycle adder. Adds or subtracts two WIDTH-bit operands. The carry chain is split into CHUNK-bit segments, one pipeline stage per segment, so the block closes timing at wide widths. It exposes a valid/ready stream interface with backpressure and reports Cout, signed overflow and zero flags. It sits in the ALU datapath in place of the combinational adder where width or clock rate demands pipelining.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits of carry chain resolved per pipeline stage.
- STAGES, WIDTH/CHUNK: derived value, not overridable. Equals pipeline depth and latency in cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B and Sub are valid this cycle.
- in_ready  output  1  block accepts an operand pair this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0: A+B; 1: A−B, computed as A + ~B + 1.
- out_valid  output  1  Sum and all flags are valid.
- out_ready  input  1  downstream accepts the result.
- Sum  output  WIDTH  result modulo 2^WIDTH.
- Cout  output  1  carry out of MSB. For Sub, 1 means no borrow (A ≥ B unsigned).
- Ovf  output  1  signed two's-complement overflow.
- Zero  output  1  1 when Sum == 0.

Behaviour:
Reset and interface decisions:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- On reset, every stage valid bit, out_valid, Sum, Cout, Ovf and Zero clear to 0. All pipeline data registers also clear to 0.

Handshake:
- Global stall rule: advance = out_ready OR NOT out_valid. in_ready = advance.
- An input is accepted when in_valid AND in_ready.
- When advance = 1, every stage shifts forward by one. A bubble (valid=0) enters stage 0 if no input is accepted.
- When advance = 0, all stage registers hold, including data, carries and valid bits. Output values stay stable while out_valid=1 and out_ready=0.
- Results leave in acceptance order. No reordering, no drops, no duplicates.

Latency and throughput:
- Latency is exactly STAGES cycles from acceptance to out_valid with no stall, e.g. 4 for the defaults.
- Throughput is one result per cycle with out_ready held high.

Datapath:
- Stage 0 registers B' = B XOR {WIDTH{Sub}} and carry-in = Sub.
- Stage k (0..STAGES−1) adds chunk k of A and B' with the carry registered by stage k−1, giving a CHUNK-bit sum chunk and a carry.
- Unprocessed upper operand chunks travel forward in skew registers. Completed lower sum chunks travel forward in deskew registers.
- Final stage:
  - Cout = carry out of top chunk.
  - Ovf = (A[MSB] == B'[MSB]) AND (Sum[MSB] != A[MSB]).
  - Sum, Cout and Ovf are registered.
  - Zero = NOR of the registered Sum.
- No saturation. Sum wraps modulo 2^WIDTH.

Boundary conditions:
- STAGES = 1 (CHUNK = WIDTH) degenerates to a registered adder with latency 1. It must still honour the handshake.
- Simultaneous out_ready=1 and new input with a full pipeline: the oldest result retires and the new input enters in the same cycle. No bubble is inserted.
- rst asserted mid-operation: all in-flight operations are discarded. out_valid=0 on the cycle after the reset edge.
- in_ready is 1 during reset and the first cycle after it, since out_valid=0.
- Inputs with in_valid=0 are ignored regardless of value.

Test Plan:
All scenarios use WIDTH=32, CHUNK=8 (latency 4).
1. A=0xFFFFFFFF, B=0x00000001, Sub=0 -> 4 cycles later Sum=0x00000000, Cout=1, Zero=1, Ovf=0. Exercises the carry rippling through all 4 stages.
2. A=0x7FFFFFFF, B=1, Sub=0 -> Sum=0x80000000, Cout=0, Ovf=1, Zero=0. Then A=0x80000000, B=1, Sub=1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
3. A=5, B=7, Sub=1 -> Sum=0xFFFFFFFE, Cout=0 (borrow), Ovf=0. A=7, B=5, Sub=1 -> Sum=2, Cout=1.
4. Stream 10 random pairs back-to-back with out_ready=1 -> 10 results on consecutive cycles starting at cycle 4, matching a reference model in order.
5. Stream 8 pairs while toggling out_ready with a random pattern -> no loss or duplication. Sum is stable while out_valid=1 and out_ready=0. in_ready == (out_ready OR NOT out_valid) every cycle.
6. Accept 3 operations, assert rst for 1 cycle mid-flight -> out_valid=0 and all outputs 0 after the reset edge. The next input returns its correct result exactly 4 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with a CHUNK-bit carry segment per stage.
// Valid/ready stream interface with a global stall; reports Cout, Ovf and Zero.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int STAGES = WIDTH / CHUNK;

    // Per-stage registers: operands (skew), partial sum (deskew), carry, valid.
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // Inputs seen by each stage: ports for stage 0, previous register otherwise.
    logic [WIDTH-1:0] a_src_s   [STAGES];
    logic [WIDTH-1:0] b_src_s   [STAGES];
    logic [WIDTH-1:0] sum_src_s [STAGES];
    logic             cin_src_s [STAGES];
    logic             vld_src_s [STAGES];

    logic [CHUNK:0]   chunk_s   [STAGES];
    logic [WIDTH-1:0] sum_d     [STAGES];
    logic             carry_d   [STAGES];
    logic             ovf_d;
    logic             zero_d;
    logic             advance_s;

    assign advance_s = out_ready | ~out_valid;
    assign in_ready  = advance_s;
    assign out_valid = valid_q[STAGES-1];
    assign Sum       = sum_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

    // Stage source selection; bubbles enter with zeroed data so idle inputs never leak in.
    always_comb begin
        if (in_valid) begin
            a_src_s[0]   = A;
            b_src_s[0]   = B ^ {WIDTH{Sub}};
            cin_src_s[0] = Sub;
        end else begin
            a_src_s[0]   = {WIDTH{1'b0}};
            b_src_s[0]   = {WIDTH{1'b0}};
            cin_src_s[0] = 1'b0;
        end
        sum_src_s[0] = {WIDTH{1'b0}};
        vld_src_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src_s[k]   = a_q[k-1];
            b_src_s[k]   = b_q[k-1];
            sum_src_s[k] = sum_q[k-1];
            cin_src_s[k] = carry_q[k-1];
            vld_src_s[k] = valid_q[k-1];
        end
    end

    // Chunk adders: stage k resolves bits [k*CHUNK +: CHUNK] and forwards its carry.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk_s[k] = {1'b0, a_src_s[k][k*CHUNK +: CHUNK]}
                       + {1'b0, b_src_s[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, cin_src_s[k]};
            sum_d[k] = sum_src_s[k];
            sum_d[k][k*CHUNK +: CHUNK] = chunk_s[k][CHUNK-1:0];
            carry_d[k] = chunk_s[k][CHUNK];
        end
        // B here is already inverted for subtraction, so one rule covers add and sub.
        ovf_d  = (a_src_s[STAGES-1][WIDTH-1] == b_src_s[STAGES-1][WIDTH-1])
               & (sum_d[STAGES-1][WIDTH-1] != a_src_s[STAGES-1][WIDTH-1]);
        zero_d = vld_src_s[STAGES-1] & ~(|sum_d[STAGES-1]);
    end

    // Pipeline registers: clear on reset, shift together on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= {WIDTH{1'b0}};
                b_q[k]     <= {WIDTH{1'b0}};
                sum_q[k]   <= {WIDTH{1'b0}};
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_src_s[k];
                b_q[k]     <= b_src_s[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= vld_src_s[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, CHUNK=8): vector table,
// random streams with and without backpressure, mid-flight reset; scoreboard queue.
module tb_pipelined_addsub;

    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Sub;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Sum;
    logic        Cout;
    logic        Ovf;
    logic        Zero;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Downstream: always ready, or a random ready pattern while rand_rdy is set.
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [32:0] r;
        r = sub ? ({1'b0, a} - {1'b0, b} + 33'h1_0000_0000) : ({1'b0, a} + {1'b0, b});
        e.sum  = r[31:0];
        e.cout = r[32];
        if (sub) e.ovf = (a[31] != b[31]) && (r[31] != a[31]);
        else     e.ovf = (a[31] == b[31]) && (r[31] != a[31]);
        e.zero = (r[31:0] == 32'h0);
        e.due  = 0;
        return e;
    endfunction

    // Output monitor: handshake rule, hold-while-stalled, scoreboard and latency checks.
    logic [31:0] p_sum;
    logic        p_cout, p_ovf, p_zero, p_stall = 1'b0;
    exp_t        m_e;
    always @(negedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            n_cmp++;
            if (in_ready !== (out_ready || !out_valid)) begin
                n_fail++;
                $display("FAIL in_ready_rule: got %b want %b", in_ready, (out_ready || !out_valid));
            end
            if (p_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || Sum !== p_sum || Cout !== p_cout || Ovf !== p_ovf || Zero !== p_zero) begin
                    n_fail++;
                    $display("FAIL hold: got v=%b sum=%h c=%b o=%b z=%b want v=1 sum=%h c=%b o=%b z=%b",
                             out_valid, Sum, Cout, Ovf, Zero, p_sum, p_cout, p_ovf, p_zero);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious: got sum=%h with out_valid=1 want no output", Sum);
                end else begin
                    m_e = exp_q.pop_front();
                    if (Sum !== m_e.sum || Cout !== m_e.cout || Ovf !== m_e.ovf || Zero !== m_e.zero) begin
                        n_fail++;
                        $display("FAIL result: got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                                 Sum, Cout, Ovf, Zero, m_e.sum, m_e.cout, m_e.ovf, m_e.zero);
                    end
                    if (lat_chk) begin
                        n_cmp++;
                        if (cyc != m_e.due) begin
                            n_fail++;
                            $display("FAIL latency: got cycle %0d want cycle %0d", cyc, m_e.due);
                        end
                    end
                end
            end
            p_stall = out_valid && !out_ready;
            p_sum = Sum; p_cout = Cout; p_ovf = Ovf; p_zero = Zero;
        end
    end

    // Drive one operand pair (called just after a rising edge) until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
        bit ok = 1'b0;
        A = a; B = b; Sub = s; in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.due = cyc + STAGES;
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        A = $urandom; B = $urandom; Sub = 1'($urandom_range(0, 1));
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles want acceptance");
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        n_cmp++;
        if (out_valid !== 1'b0 || Sum !== 32'h0 || Cout !== 1'b0 || Ovf !== 1'b0 || Zero !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got v=%b sum=%h c=%b o=%b z=%b rdy=%b want v=0 sum=0 c=0 o=0 z=0 rdy=1",
                     name, out_valid, Sum, Cout, Ovf, Zero, in_ready);
        end
    endtask

    vec_t vt[10];
    exp_t te;

    initial begin
        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vt[8] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0};
        vt[9] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; A = 32'h0; B = 32'h0; Sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset_state");
        @(posedge clk);
        #1;

        // Directed vectors back-to-back, exact latency.
        for (int i = 0; i < 10; i++) begin
            te = '{vt[i].sum, vt[i].cout, vt[i].ovf, vt[i].zero, 0};
            send(vt[i].a, vt[i].b, vt[i].sub, te);
        end
        drain();

        // Ten random pairs streamed with out_ready high.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();

        // Eight pairs with random backpressure and random input gaps.
        lat_chk = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lat_chk = 1'b1;

        // Reset with three operations in flight: all discarded.
        send(32'h0000_0001, 32'h0000_0002, 1'b0, model(32'h0000_0001, 32'h0000_0002, 1'b0));
        send(32'h0000_0003, 32'h0000_0004, 1'b0, model(32'h0000_0003, 32'h0000_0004, 1'b0));
        send(32'h0000_0009, 32'h0000_0001, 1'b1, model(32'h0000_0009, 32'h0000_0001, 1'b1));
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_in_midreset: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midflight_reset");
        @(posedge clk);
        #1;
        te = '{32'h2345_6789, 1'b0, 1'b0, 1'b0, 0};
        send(32'h1234_5678, 32'h1111_1111, 1'b0, te);
        drain();
        repeat (6) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
